// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC/SD SPI host engine.
package mmc_pkg;

  localparam int   MMC_BYTE_W  = 8;
  localparam logic MMC_DI_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SCK_LO,
    SCK_HI
  } mmc_spi_state_t;

endpackage

// File: rtl/mmc_sclk_div.sv
// Loadable down-counter that pulses tick once every CLK_DIV enabled cycles.
module mmc_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 8'd0);

  // Terminal count reloads so every phase lasts exactly CLK_DIV cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmc_spi_host.sv
// SPI mode-0 byte engine for an MMC/SD card: one byte per start/done handshake,
// MSB first, with a registered active-low card select that only moves while idle.
module mmc_spi_host
  import mmc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MMC_BYTE_W-1:0] tx_byte,
  input  logic                  cs_req,
  output logic                  busy,
  output logic                  done,
  output logic [MMC_BYTE_W-1:0] rx_byte,
  output logic                  mmc_cs,
  output logic                  mmc_di,
  input  logic                  mmc_do,
  output logic                  mmc_sclk
);

  mmc_spi_state_t        state_q, state_d;
  logic [2:0]            bit_q, bit_d;
  logic [MMC_BYTE_W-1:0] tx_q, tx_d;
  logic [MMC_BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic [MMC_BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_q, cs_d;
  logic                  di_q, di_d;
  logic                  sclk_q, sclk_d;
  logic                  div_load;
  logic                  tick;

  mmc_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (div_load),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    di_d      = di_q;
    sclk_d    = sclk_q;
    div_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_d = ~cs_req;
        if (start) begin
          state_d  = SCK_LO;
          div_load = 1'b1;
          busy_d   = 1'b1;
          bit_d    = 3'd0;
          sclk_d   = 1'b0;
          di_d     = tx_byte[MMC_BYTE_W-1];
          tx_d     = {tx_byte[MMC_BYTE_W-2:0], 1'b0};
        end
      end
      SCK_LO: begin
        if (tick) begin
          state_d = SCK_HI;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[MMC_BYTE_W-2:0], mmc_do};
        end
      end
      SCK_HI: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_d     = 3'd0;
            di_d      = MMC_DI_IDLE;
            rx_byte_d = rx_sh_q;
          end else begin
            // Next data bit goes out together with the falling clock edge.
            state_d = SCK_LO;
            bit_d   = bit_q + 3'd1;
            di_d    = tx_q[MMC_BYTE_W-1];
            tx_d    = {tx_q[MMC_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_q     <= 3'd0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b1;
      di_q      <= MMC_DI_IDLE;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      di_q      <= di_d;
      sclk_q    <= sclk_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_byte  = rx_byte_q;
  assign mmc_cs   = cs_q;
  assign mmc_di   = di_q;
  assign mmc_sclk = sclk_q;

endmodule

// File: tb/tb_mmc_spi_host.sv
// Bench for mmc_spi_host: two instances (CLK_DIV 4 and 1) checked every cycle
// against a timing-formula model, plus directed literal checks.
module tb_mmc_spi_host;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic [7:0] txb   [2];
  logic       csr   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rxb   [2];
  logic       csn   [2];
  logic       di    [2];
  logic       mdo   [2];
  logic       sclk  [2];
  logic       loop  [2];
  logic [7:0] card  [2];
  int         cbase [2];
  int         n_rise[2];
  int         n_done[2];
  logic [7:0] di_seq[2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(string name, int act, int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  mmc_spi_host #(.CLK_DIV(D0)) u_d4 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .tx_byte(txb[0]), .cs_req(csr[0]),
    .busy(busy[0]), .done(done[0]), .rx_byte(rxb[0]), .mmc_cs(csn[0]),
    .mmc_di(di[0]), .mmc_do(mdo[0]), .mmc_sclk(sclk[0])
  );

  mmc_spi_host #(.CLK_DIV(D1)) u_d1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .tx_byte(txb[1]), .cs_req(csr[1]),
    .busy(busy[1]), .done(done[1]), .rx_byte(rxb[1]), .mmc_cs(csn[1]),
    .mmc_di(di[1]), .mmc_do(mdo[1]), .mmc_sclk(sclk[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int D = (g == 0) ? D0 : D1;

    // Card drives bit (7 - rises so far in this byte); loopback echoes mmc_di.
    assign mdo[g] = loop[g] ? di[g] : card[g][3'(7 - ((n_rise[g] - cbase[g]) % 8))];

    bit         act   = 0;
    int         t     = 0;
    logic [7:0] mtx   = '0;
    logic [7:0] mrx   = '0;
    logic [7:0] erx   = '0;
    bit         edone = 0;
    logic       ecs   = 1'b1;
    logic       prev_sclk = 1'b0;

    always @(posedge clk) begin
      edone = 0;
      if (rst[g]) begin
        act = 0; t = 0; erx = '0; ecs = 1'b1;
      end else if (act) begin
        t = t + 1;
        if (t == 16 * D) begin
          act = 0; edone = 1; erx = mrx;
        end
      end else begin
        ecs = ~csr[g];
        if (start[g]) begin
          act = 1; t = 0; mtx = txb[g];
          mrx = loop[g] ? txb[g] : card[g];
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("busy%0d", g), int'(busy[g]), int'(act));
        check($sformatf("done%0d", g), int'(done[g]), int'(edone));
        check($sformatf("sclk%0d", g), int'(sclk[g]), act ? ((t / D) % 2) : 0);
        check($sformatf("di%0d", g), int'(di[g]), act ? int'(mtx[3'(7 - t / (2 * D))]) : 1);
        check($sformatf("cs%0d", g), int'(csn[g]), int'(ecs));
        check($sformatf("rx%0d", g), int'(rxb[g]), int'(erx));
      end
      if (sclk[g] && !prev_sclk) begin
        n_rise[g] = n_rise[g] + 1;
        di_seq[g] = {di_seq[g][6:0], di[g]};
      end
      if (done[g]) n_done[g] = n_done[g] + 1;
      prev_sclk = sclk[g];
    end
  end

  // Entered and left at posedge+#1; the start cycle is the current one.
  task automatic xfer(input int g, input logic [7:0] tx, input logic lp,
                      input logic [7:0] cb, input logic cs,
                      output int lat, output logic [7:0] rx);
    int c0;
    int k;
    loop[g]  = lp;
    card[g]  = cb;
    cbase[g] = n_rise[g];
    txb[g]   = tx;
    csr[g]   = cs;
    start[g] = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start[g] = 1'b0;
    k = 0;
    while (!done[g] && k < 640) begin
      @(posedge clk); #1;
      k = k + 1;
    end
    if (!done[g]) begin
      check("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = cyc - c0;
    end
    rx = rxb[g];
  endtask

  initial begin
    int         lat;
    int         nd;
    int         nr;
    int         c0;
    int         k;
    int         g;
    logic [7:0] rx;
    logic [7:0] tx;
    logic [7:0] cb;
    logic       lp;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; txb[i] = '0; csr[i] = 1'b0;
      loop[i] = 1'b1; card[i] = '0; cbase[i] = 0;
      n_rise[i] = 0; n_done[i] = 0; di_seq[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_rx", int'(rxb[0]), 8'h00);
    check("rst_cs", int'(csn[0]), 1);
    check("rst_di", int'(di[0]), 1);
    check("rst_sclk", int'(sclk[0]), 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Loopback A5 at CLK_DIV=4
    nr = n_rise[0];
    xfer(0, 8'hA5, 1'b1, 8'h00, 1'b1, lat, rx);
    check("lb_lat", lat, 65);
    check("lb_rx", int'(rx), 8'hA5);
    check("lb_rises", n_rise[0] - nr, 8);
    check("lb_di_seq", int'(di_seq[0]), 8'hA5);

    // Card returns 3C while host sends FF
    xfer(0, 8'hFF, 1'b0, 8'h3C, 1'b1, lat, rx);
    check("card_rx", int'(rx), 8'h3C);
    check("card_di_seq", int'(di_seq[0]), 8'hFF);
    check("card_cs", int'(csn[0]), 0);

    // Starts during busy are ignored
    repeat (2) @(posedge clk);
    #1;
    nd = n_done[0]; nr = n_rise[0];
    loop[0] = 1'b1; txb[0] = 8'h5A; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1; start[0] = 1'b1; txb[0] = 8'h0F;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (34) @(posedge clk);
    #1; start[0] = 1'b1; txb[0] = 8'hF0;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("ign_dones", n_done[0] - nd, 1);
    check("ign_rises", n_rise[0] - nr, 8);
    check("ign_rx", int'(rxb[0]), 8'h5A);

    // cs_req dropped mid-byte
    csr[0] = 1'b1; txb[0] = 8'h81; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1; csr[0] = 1'b0;
    k = 0;
    while (!done[0] && k < 200) begin
      @(posedge clk); #1; k = k + 1;
    end
    check("csdrop_done_seen", int'(done[0]), 1);
    check("csdrop_cs_at_done", int'(csn[0]), 0);
    @(posedge clk); #1;
    check("csdrop_cs_after", int'(csn[0]), 1);

    // Reset after the third rising edge aborts the byte
    csr[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nd = n_done[0]; nr = n_rise[0];
    txb[0] = 8'h77; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    k = 0;
    while ((n_rise[0] - nr) < 3 && k < 200) begin
      @(posedge clk); #1; k = k + 1;
    end
    check("rst_mid_rises", n_rise[0] - nr, 3);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_sclk", int'(sclk[0]), 0);
    check("abort_di", int'(di[0]), 1);
    check("abort_cs", int'(csn[0]), 1);
    check("abort_busy", int'(busy[0]), 0);
    rst[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", n_done[0] - nd, 0);

    // CLK_DIV=1 back-to-back 00 then FF
    xfer(1, 8'h00, 1'b1, 8'h00, 1'b1, lat, rx);
    check("d1_lat0", lat, 17);
    check("d1_rx0", int'(rx), 8'h00);
    xfer(1, 8'hFF, 1'b1, 8'h00, 1'b1, lat, rx);
    check("d1_lat1", lat, 17);
    check("d1_rx1", int'(rx), 8'hFF);

    // Randomized transfers on both instances
    for (int i = 0; i < 24; i++) begin
      g  = int'($urandom_range(0, 1));
      tx = 8'($urandom);
      cb = 8'($urandom);
      lp = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      xfer(g, tx, lp, cb, 1'($urandom), lat, rx);
      check("rnd_lat", lat, 16 * ((g == 0) ? D0 : D1) + 1);
      check("rnd_rx", int'(rx), int'(lp ? tx : cb));
    end

    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
